// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution MAC engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

  localparam int CONV_DATA_WIDTH = 32;
  localparam int CONV_FRAC_BITS  = 16;

  // Working width for saturation; must exceed any sum width used by the engine.
  localparam int SAT_W = 128;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Clamp a wide signed value into the signed range of 'width' bits.
  // The result stays SAT_W wide; callers keep the low 'width' bits.
  function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] value,
                                                      input int width);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    hi  = (one << (width - 1)) - one;
    lo  = ~hi;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/conv_round_sat.sv
// Round-half-up, saturate, optional partial-sum add with re-saturation, optional ReLU.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module conv_round_sat
  import conv_pkg::*;
#(
  parameter int IN_W = 69,
  parameter int DW   = 32,
  parameter int F    = 16
) (
  input  logic signed [IN_W-1:0] sum,
  input  logic                   acc_en,
  input  logic                   relu_en,
  input  logic signed [DW-1:0]   psum,
  output logic signed [DW-1:0]   result
);

  logic signed [SAT_W-1:0] sum_x;
  logic signed [SAT_W-1:0] rnd;
  logic signed [SAT_W-1:0] acc_x;
  logic signed [DW-1:0]    r1;
  logic signed [DW-1:0]    r2;

  assign sum_x = SAT_W'(sum);

  generate
    if (F > 0) begin : g_rnd
      logic signed [SAT_W-1:0] half;
      assign half = {{(SAT_W-1){1'b0}}, 1'b1} << (F - 1);
      assign rnd  = (sum_x + half) >>> F;
    end else begin : g_nornd
      assign rnd = sum_x;
    end
  endgenerate

  // Saturate the rounded product sum, then fold in the chained partial sum and ReLU.
  always_comb begin
    r1     = DW'(sat_to(rnd, DW));
    acc_x  = SAT_W'(r1) + SAT_W'(psum);
    r2     = acc_en ? DW'(sat_to(acc_x, DW)) : r1;
    result = (relu_en && r2[DW-1]) ? '0 : r2;
  end

endmodule

// File: rtl/conv_mac_array.sv
// K x K convolution dot product over a shift-loaded kernel bank and window, one start per cycle.
// Latency: 3 cycles from start to out_valid; fully pipelined, results in order.
// Backpressure: none; the consumer must accept every out_valid pulse.
module conv_mac_array
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int FRAC_BITS  = CONV_FRAC_BITS,
  parameter int KNL_DIM    = 5,
  parameter int KNL_MAXNUM = 16
) (
  input  logic                               clk,
  input  logic                               srstn,
  input  logic                               knl_wr,
  input  logic                               ifmap_wr,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic [clog2(KNL_MAXNUM+1)-1:0]     num_knls,
  input  logic [clog2(KNL_MAXNUM)-1:0]       knl_sel,
  input  logic                               start,
  input  logic                               acc_en,
  input  logic                               relu_en,
  input  logic [DATA_WIDTH-1:0]              psum_in,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               sel_err
);

  localparam int DW     = DATA_WIDTH;
  localparam int KK     = KNL_DIM * KNL_DIM;
  localparam int BANK   = KNL_MAXNUM * KK;
  localparam int BIW    = clog2(BANK);
  localparam int PW     = 2 * DW;
  localparam int LVL    = clog2(KK);
  localparam int SW     = PW + LVL;
  localparam int LEAVES = 1 << LVL;

  // Storage (never reset; contents are undefined until loaded).
  logic [DW-1:0] knl_bank [BANK];
  logic [DW-1:0] win      [KK];

  // Kernel selection.
  int             sel_num;
  int             sel_idx;
  logic           sel_bad;
  logic [BIW-1:0] knl_base;

  // Products and pipeline registers.
  logic signed [PW-1:0] prod    [KK];
  logic signed [PW-1:0] s1_prod [KK];
  logic                 s1_vld, s1_err, s1_acc, s1_relu;
  logic [DW-1:0]        s1_psum;
  logic signed [SW-1:0] tree    [1:2*LEAVES-1];
  logic signed [SW-1:0] s2_sum;
  logic                 s2_vld, s2_err, s2_acc, s2_relu;
  logic [DW-1:0]        s2_psum;
  logic signed [DW-1:0] rs_out;

  // Kernel bank: new word enters the top index, everything else moves down one.
  always_ff @(posedge clk) begin
    if (knl_wr) begin
      for (int i = 0; i < BANK - 1; i++) knl_bank[i] <= knl_bank[i+1];
      knl_bank[BANK-1] <= data_in;
    end
  end

  // Window: same shift rule as the kernel bank.
  always_ff @(posedge clk) begin
    if (ifmap_wr) begin
      for (int i = 0; i < KK - 1; i++) win[i] <= win[i+1];
      win[KK-1] <= data_in;
    end
  end

  // Resolve the selected kernel's base word; kernels are packed against the top of the bank.
  always_comb begin
    sel_num  = int'(num_knls);
    sel_idx  = int'(knl_sel);
    sel_bad  = (sel_num == 0) || (sel_num > KNL_MAXNUM) || (sel_idx >= sel_num);
    knl_base = sel_bad ? '0 : BIW'((KNL_MAXNUM - sel_num + sel_idx) * KK);
  end

  // Kernel is row-major, window column-major: kernel word r*K+s meets window word s*K+r.
  genvar gr, gs;
  generate
    for (gr = 0; gr < KNL_DIM; gr++) begin : g_row
      for (gs = 0; gs < KNL_DIM; gs++) begin : g_col
        assign prod[gr*KNL_DIM+gs] =
            PW'($signed(knl_bank[knl_base + BIW'(gr*KNL_DIM+gs)])) *
            PW'($signed(win[gs*KNL_DIM+gr]));
      end
    end
  endgenerate

  // Stage 1 data: products and per-start controls, captured only on start.
  always_ff @(posedge clk) begin
    if (start) begin
      s1_prod <= prod;
      s1_err  <= sel_bad;
      s1_acc  <= acc_en;
      s1_relu <= relu_en;
      s1_psum <= psum_in;
    end
  end

  // Binary adder tree padded to a power of two; sum width covers every carry.
  genvar gl, gn;
  generate
    for (gl = 0; gl < LEAVES; gl++) begin : g_leaf
      if (gl < KK) begin : g_used
        assign tree[LEAVES+gl] = SW'(s1_prod[gl]);
      end else begin : g_pad
        assign tree[LEAVES+gl] = '0;
      end
    end
    for (gn = 1; gn < LEAVES; gn++) begin : g_node
      assign tree[gn] = tree[2*gn] + tree[2*gn+1];
    end
  endgenerate

  // Stage 2 data: tree sum plus controls carried along.
  always_ff @(posedge clk) begin
    if (s1_vld) begin
      s2_sum  <= tree[1];
      s2_err  <= s1_err;
      s2_acc  <= s1_acc;
      s2_relu <= s1_relu;
      s2_psum <= s1_psum;
    end
  end

  conv_round_sat #(
    .IN_W (SW),
    .DW   (DW),
    .F    (FRAC_BITS)
  ) u_round_sat (
    .sum     (s2_sum),
    .acc_en  (s2_acc),
    .relu_en (s2_relu),
    .psum    ($signed(s2_psum)),
    .result  (rs_out)
  );

  // Stage valids and the output register; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      data_out  <= '0;
    end else begin
      s1_vld    <= start;
      s2_vld    <= s1_vld;
      out_valid <= s2_vld;
      sel_err   <= s2_vld & s2_err;
      if (s2_vld) data_out <= s2_err ? '0 : rs_out;
    end
  end

endmodule

// File: tb/tb_conv_mac_array.sv
// Directed bench for conv_mac_array with hand-computed results.
// Latency: checks the 3-cycle start-to-result delay on every operation.
// Backpressure: n/a; inputs are driven and outputs sampled on the falling edge.
module tb_conv_mac_array;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          srstn;
  logic          knl_wr;
  logic          ifmap_wr;
  logic [DW-1:0] data_in;
  logic [4:0]    num_knls;
  logic [3:0]    knl_sel;
  logic          start;
  logic          acc_en;
  logic          relu_en;
  logic [DW-1:0] psum_in;
  logic          out_valid;
  logic [DW-1:0] data_out;
  logic          sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_mac_array #(
    .DATA_WIDTH (32),
    .FRAC_BITS  (16),
    .KNL_DIM    (5),
    .KNL_MAXNUM (16)
  ) dut (
    .clk       (clk),
    .srstn     (srstn),
    .knl_wr    (knl_wr),
    .ifmap_wr  (ifmap_wr),
    .data_in   (data_in),
    .num_knls  (num_knls),
    .knl_sel   (knl_sel),
    .start     (start),
    .acc_en    (acc_en),
    .relu_en   (relu_en),
    .psum_in   (psum_in),
    .out_valid (out_valid),
    .data_out  (data_out),
    .sel_err   (sel_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_knl(input logic [31:0] w);
    data_in = w;
    knl_wr  = 1'b1;
    @(negedge clk);
    knl_wr  = 1'b0;
  endtask

  task automatic push_win(input logic [31:0] w);
    data_in  = w;
    ifmap_wr = 1'b1;
    @(negedge clk);
    ifmap_wr = 1'b0;
  endtask

  // Word 'hot' gets hot_val, all others get rest; hot = -1 gives a uniform load.
  task automatic load_knl(input int hot, input logic [31:0] hot_val, input logic [31:0] rest);
    for (int j = 0; j < 25; j++) push_knl((j == hot) ? hot_val : rest);
  endtask

  task automatic load_win(input int hot, input logic [31:0] hot_val, input logic [31:0] rest);
    for (int j = 0; j < 25; j++) push_win((j == hot) ? hot_val : rest);
  endtask

  // One start, then wait (bounded) for its result and check latency, data and error flag.
  task automatic run_op(input string tag, input logic [3:0] sel, input logic acc,
                        input logic relu, input logic [31:0] psum,
                        input logic [31:0] exp_dat, input logic exp_err);
    int lat;
    lat     = 0;
    knl_sel = sel;
    acc_en  = acc;
    relu_en = relu;
    psum_in = psum;
    start   = 1'b1;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) lat = c;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd3);
    check_eq({tag, "_dat"}, 64'(data_out), 64'(exp_dat));
    check_eq({tag, "_err"}, 64'(sel_err), 64'(exp_err));
  endtask

  initial begin
    int seen;
    bit exp_v;

    srstn    = 1'b0;
    knl_wr   = 1'b0;
    ifmap_wr = 1'b0;
    start    = 1'b1;
    acc_en   = 1'b0;
    relu_en  = 1'b0;
    data_in  = '0;
    psum_in  = '0;
    num_knls = 5'd1;
    knl_sel  = 4'd0;

    // Reset values, with start held high throughout reset.
    repeat (3) @(negedge clk);
    check_eq("rst_vld", 64'(out_valid), 64'd0);
    check_eq("rst_err", 64'(sel_err), 64'd0);
    check_eq("rst_dat", 64'(data_out), 64'd0);
    srstn = 1'b1;
    start = 1'b0;
    seen  = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check_eq("rst_start_ignored", 64'(seen), 64'd0);

    // 25 x (1.0 * 2.0) = 50.0
    load_knl(-1, '0, 32'h0001_0000);
    load_win(-1, '0, 32'h0002_0000);
    run_op("basic", 4'd0, 1'b0, 1'b0, '0, 32'h0032_0000, 1'b0);
    @(negedge clk);
    check_eq("basic_one_cycle", 64'(out_valid), 64'd0);
    check_eq("basic_hold", 64'(data_out), 64'h0032_0000);

    // Chaining: 50.0 + 1.0
    run_op("chain", 4'd0, 1'b1, 1'b0, 32'h0001_0000, 32'h0033_0000, 1'b0);

    // Saturation, both directions, and saturation around the psum add.
    load_knl(-1, '0, 32'h7FFF_FFFF);
    load_win(-1, '0, 32'h7FFF_FFFF);
    run_op("sat_pos", 4'd0, 1'b0, 1'b0, '0, 32'h7FFF_FFFF, 1'b0);
    run_op("sat_acc_pos", 4'd0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    run_op("sat_acc_neg", 4'd0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    load_win(-1, '0, 32'h8000_0001);
    run_op("sat_neg", 4'd0, 1'b0, 1'b0, '0, 32'h8000_0000, 1'b0);
    run_op("sat_neg_relu", 4'd0, 1'b0, 1'b1, '0, 32'h0000_0000, 1'b0);

    // Rounding: kernel word 8 (row 1, col 3) pairs with window word 16.
    load_knl(8, 32'h0000_0001, '0);
    load_win(16, 32'h0000_8000, '0);
    run_op("rnd_half_up", 4'd0, 1'b0, 1'b0, '0, 32'h0000_0001, 1'b0);
    load_win(16, 32'hFFFF_8000, '0);
    run_op("rnd_neg_half", 4'd0, 1'b0, 1'b0, '0, 32'h0000_0000, 1'b0);

    // ReLU on a -1.0 result.
    load_knl(0, 32'hFFFF_0000, '0);
    load_win(0, 32'h0001_0000, '0);
    run_op("neg_one", 4'd0, 1'b0, 1'b0, '0, 32'hFFFF_0000, 1'b0);
    run_op("relu", 4'd0, 1'b0, 1'b1, '0, 32'h0000_0000, 1'b0);

    // Bank select: kernel c word j holds raw 25c+j+1; window 1.0 gives sum 625c+325.
    num_knls = 5'd4;
    for (int p = 0; p < 100; p++) push_knl(32'(p + 1));
    load_win(-1, '0, 32'h0001_0000);
    for (int c = 0; c < 4; c++)
      run_op($sformatf("bank%0d", c), 4'(c), 1'b0, 1'b0, '0, 32'(325 + 625 * c), 1'b0);
    run_op("sel_oob", 4'd4, 1'b0, 1'b0, '0, 32'h0, 1'b1);
    num_knls = 5'd0;
    run_op("sel_none", 4'd0, 1'b0, 1'b0, '0, 32'h0, 1'b1);
    num_knls = 5'd17;
    run_op("sel_over", 4'd0, 1'b0, 1'b0, '0, 32'h0, 1'b1);
    num_knls = 5'd1;
    run_op("sel_ok_after_err", 4'd0, 1'b0, 1'b0, '0, 32'(2200), 1'b0);

    // Pipeline: window raw 1..25, one shift per start; start i sums to 325+99i.
    load_knl(-1, '0, 32'h0001_0000);
    for (int j = 0; j < 25; j++) push_win(32'(j + 1));
    knl_sel = 4'd0;
    acc_en  = 1'b0;
    relu_en = 1'b0;
    for (int k = 0; k < 13; k++) begin
      exp_v = (k >= 3 && k <= 10);
      check_eq($sformatf("pipe_vld%0d", k), 64'(out_valid), 64'(exp_v));
      if (exp_v) check_eq($sformatf("pipe_dat%0d", k), 64'(data_out), 64'(325 + 99 * (k - 3)));
      start    = (k < 8);
      ifmap_wr = (k < 8);
      data_in  = 32'(100 + k);
      @(negedge clk);
    end
    start    = 1'b0;
    ifmap_wr = 1'b0;

    // Mid-pipeline reset: reset coincides with the third start, killing all three;
    // starts after release come out 3 cycles later with 25.0.
    load_win(-1, '0, 32'h0001_0000);
    for (int k = 0; k < 10; k++) begin
      exp_v = (k == 6 || k == 7);
      check_eq($sformatf("mrst_vld%0d", k), 64'(out_valid), 64'(exp_v));
      if (k == 3) check_eq("mrst_dat_clr", 64'(data_out), 64'd0);
      if (exp_v) check_eq($sformatf("mrst_dat%0d", k), 64'(data_out), 64'h0019_0000);
      start = (k <= 4);
      srstn = (k != 2);
      @(negedge clk);
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
